// File: rtl/pat_evt_monitor_if.sv
// Window-monitor port bundle: detector inputs, per-window report handshake, status outputs.
// slave = monitor side, master = the block driving detections and consuming reports.
interface pat_evt_monitor_if #(
  parameter int CNT_W = 16
);
  logic             en_i;
  logic             clr_i;
  logic             valid_i;
  logic             pattern_detected_i;
  logic             rpt_ready_i;
  logic [CNT_W-1:0] total_cnt_o;
  logic             rpt_valid_o;
  logic [CNT_W-1:0] rpt_cnt_o;
  logic             rpt_hot_o;
  logic             alarm_o;
  logic             overrun_o;

  modport slave (
    input  en_i, clr_i, valid_i, pattern_detected_i, rpt_ready_i,
    output total_cnt_o, rpt_valid_o, rpt_cnt_o, rpt_hot_o, alarm_o, overrun_o
  );

  modport master (
    output en_i, clr_i, valid_i, pattern_detected_i, rpt_ready_i,
    input  total_cnt_o, rpt_valid_o, rpt_cnt_o, rpt_hot_o, alarm_o, overrun_o
  );
endinterface

// File: rtl/pat_evt_monitor.sv
// Windowed detection counter with per-window report, lifetime total and hot-streak alarm.
// Report visible 1 cycle after window close; a close against an unaccepted report drops it and sets overrun.
module pat_evt_monitor #(
  parameter int WIN_LEN = 64,
  parameter int CNT_W   = 16,
  parameter int THRESH  = 4,
  parameter int CONSEC  = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  pat_evt_monitor_if.slave bus
);
  localparam int SLOT_W = $clog2(WIN_LEN);
  localparam int STRK_W = $clog2(CONSEC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_CLEAR  = 2'd0,
    S_ARMED  = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [CNT_W-1:0]  win_q, win_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic              rpt_vld_q, rpt_vld_d;
  logic [CNT_W-1:0]  rpt_cnt_q, rpt_cnt_d;
  logic              rpt_hot_q, rpt_hot_d;
  logic              ovr_q, ovr_d;
  state_t            state_q;
  logic [STRK_W-1:0] streak_q;
  logic              alarm_q;

  logic             pulse;
  logic             close;
  logic [CNT_W-1:0] win_inc;
  logic [CNT_W-1:0] close_cnt;
  logic             close_hot;
  logic             rpt_take;

  assign pulse     = bus.en_i & bus.pattern_detected_i;
  assign close     = bus.en_i & bus.valid_i & (slot_q == SLOT_W'(WIN_LEN - 1));
  assign win_inc   = (win_q == CNT_MAX) ? win_q : win_q + CNT_W'(1);
  // A pulse in the close cycle is folded into the closing window, not the next one.
  assign close_cnt = pulse ? win_inc : win_q;
  assign close_hot = (close_cnt >= CNT_W'(THRESH));
  assign rpt_take  = ~rpt_vld_q | bus.rpt_ready_i;

  always_comb begin
    slot_d    = slot_q;
    win_d     = win_q;
    total_d   = total_q;
    rpt_vld_d = rpt_vld_q;
    rpt_cnt_d = rpt_cnt_q;
    rpt_hot_d = rpt_hot_q;
    ovr_d     = ovr_q;

    if (rpt_vld_q && bus.rpt_ready_i) begin
      rpt_vld_d = 1'b0;
    end
    if (pulse) begin
      win_d   = win_inc;
      total_d = (total_q == CNT_MAX) ? total_q : total_q + CNT_W'(1);
    end
    if (bus.en_i && bus.valid_i) begin
      slot_d = close ? '0 : slot_q + SLOT_W'(1);
    end
    if (close) begin
      win_d = '0;
      if (rpt_take) begin
        rpt_vld_d = 1'b1;
        rpt_cnt_d = close_cnt;
        rpt_hot_d = close_hot;
      end else begin
        ovr_d = 1'b1;
      end
    end
    if (bus.clr_i) begin
      slot_d    = '0;
      win_d     = '0;
      total_d   = '0;
      rpt_vld_d = 1'b0;
      rpt_cnt_d = '0;
      rpt_hot_d = 1'b0;
      ovr_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      slot_q    <= '0;
      win_q     <= '0;
      total_q   <= '0;
      rpt_vld_q <= 1'b0;
      rpt_cnt_q <= '0;
      rpt_hot_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      slot_q    <= slot_d;
      win_q     <= win_d;
      total_q   <= total_d;
      rpt_vld_q <= rpt_vld_d;
      rpt_cnt_q <= rpt_cnt_d;
      rpt_hot_q <= rpt_hot_d;
      ovr_q     <= ovr_d;
    end
  end

  // Scored on every close, including windows whose report was dropped.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_CLEAR;
      streak_q <= '0;
      alarm_q  <= 1'b0;
    end else if (bus.clr_i) begin
      state_q  <= S_CLEAR;
      streak_q <= '0;
      alarm_q  <= 1'b0;
    end else if (close) begin
      case (state_q)
        S_CLEAR: begin
          if (close_hot) begin
            streak_q <= STRK_W'(1);
            if (CONSEC == 1) begin
              state_q <= S_ACTIVE;
              alarm_q <= 1'b1;
            end else begin
              state_q <= S_ARMED;
            end
          end
        end
        S_ARMED: begin
          if (close_hot) begin
            streak_q <= streak_q + STRK_W'(1);
            if ((streak_q + STRK_W'(1)) >= STRK_W'(CONSEC)) begin
              state_q <= S_ACTIVE;
              alarm_q <= 1'b1;
            end
          end else begin
            streak_q <= '0;
            state_q  <= S_CLEAR;
          end
        end
        S_ACTIVE: begin
          if (!close_hot) begin
            streak_q <= '0;
            state_q  <= S_CLEAR;
            alarm_q  <= 1'b0;
          end
        end
        default: begin
          streak_q <= '0;
          state_q  <= S_CLEAR;
          alarm_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.total_cnt_o = total_q;
  assign bus.rpt_valid_o = rpt_vld_q;
  assign bus.rpt_cnt_o   = rpt_cnt_q;
  assign bus.rpt_hot_o   = rpt_hot_q;
  assign bus.alarm_o     = alarm_q;
  assign bus.overrun_o   = ovr_q;
endmodule

// File: tb/tb_pat_evt_monitor.sv
// Bench for pat_evt_monitor: window table plus hand-written corner sequences,
// with accepted reports checked against a queue of expected {count, hot}.
module tb_pat_evt_monitor;
  localparam int WIN_LEN = 8;
  localparam int CNT_W   = 4;
  localparam int THRESH  = 2;
  localparam int CONSEC  = 2;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  pat_evt_monitor_if #(.CNT_W(CNT_W)) bus ();

  pat_evt_monitor #(
    .WIN_LEN(WIN_LEN),
    .CNT_W  (CNT_W),
    .THRESH (THRESH),
    .CONSEC (CONSEC)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int   cnt;
    logic hot;
  } rpt_t;
  rpt_t sb[$];

  typedef struct {
    logic [7:0] mask;
    int         cnt;
    logic       hot;
    logic       alarm;
    int         total;
  } win_vec_t;
  win_vec_t tbl[8];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_rpt(input int cnt, input logic hot);
    rpt_t r;
    r.cnt = cnt;
    r.hot = hot;
    sb.push_back(r);
  endtask

  task automatic drive_window(input logic [7:0] mask, input logic rdy_body, input logic rdy_last,
                              input logic push, input int cnt, input logic hot);
    for (int s = 0; s < WIN_LEN; s++) begin
      bus.en_i               = 1'b1;
      bus.valid_i            = 1'b1;
      bus.pattern_detected_i = mask[s];
      bus.rpt_ready_i        = (s == WIN_LEN - 1) ? rdy_last : rdy_body;
      if (s == WIN_LEN - 1 && push) expect_rpt(cnt, hot);
      tick();
    end
    bus.valid_i            = 1'b0;
    bus.pattern_detected_i = 1'b0;
  endtask

  task automatic idle(input logic rdy);
    bus.valid_i            = 1'b0;
    bus.pattern_detected_i = 1'b0;
    bus.rpt_ready_i        = rdy;
    tick();
  endtask

  task automatic pulse_clr();
    bus.clr_i = 1'b1;
    tick();
    bus.clr_i = 1'b0;
  endtask

  // Scoreboard: every handshake must match the oldest expected report.
  always @(negedge clk_i) begin
    if (rst_i === 1'b1 && bus.rpt_valid_o === 1'b1 && bus.rpt_ready_i === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_expected_rpt_present", sb.size(), 1);
      end else begin
        rpt_t r;
        r = sb.pop_front();
        check("sb_rpt_cnt", int'(bus.rpt_cnt_o), r.cnt);
        check("sb_rpt_hot", int'(bus.rpt_hot_o), int'(r.hot));
      end
    end
  end

  initial begin
    tbl[0] = '{8'h00, 0, 1'b0, 1'b0, 3};
    tbl[1] = '{8'h12, 2, 1'b1, 1'b0, 5};
    tbl[2] = '{8'h49, 3, 1'b1, 1'b1, 8};
    tbl[3] = '{8'h08, 1, 1'b0, 1'b0, 9};
    tbl[4] = '{8'h12, 2, 1'b1, 1'b0, 11};
    tbl[5] = '{8'h08, 1, 1'b0, 1'b0, 12};
    tbl[6] = '{8'h12, 2, 1'b1, 1'b0, 14};
    tbl[7] = '{8'h00, 0, 1'b0, 1'b0, 14};

    rst_i                  = 1'b0;
    bus.en_i               = 1'b0;
    bus.clr_i              = 1'b0;
    bus.valid_i            = 1'b0;
    bus.pattern_detected_i = 1'b0;
    bus.rpt_ready_i        = 1'b0;
    repeat (3) tick();
    check("rst_total", int'(bus.total_cnt_o), 0);
    check("rst_rpt_valid", int'(bus.rpt_valid_o), 0);
    check("rst_rpt_cnt", int'(bus.rpt_cnt_o), 0);
    check("rst_rpt_hot", int'(bus.rpt_hot_o), 0);
    check("rst_alarm", int'(bus.alarm_o), 0);
    check("rst_overrun", int'(bus.overrun_o), 0);
    rst_i = 1'b1;
    tick();

    // Reset mid-window with 3 detections pending.
    for (int s = 0; s < 5; s++) begin
      bus.en_i               = 1'b1;
      bus.valid_i            = 1'b1;
      bus.pattern_detected_i = (s % 2 == 0);
      tick();
    end
    bus.valid_i            = 1'b0;
    bus.pattern_detected_i = 1'b0;
    check("t1_total_before_rst", int'(bus.total_cnt_o), 3);
    rst_i = 1'b0;
    #1;
    check("t1_total_in_rst", int'(bus.total_cnt_o), 0);
    check("t1_valid_in_rst", int'(bus.rpt_valid_o), 0);
    tick();
    rst_i = 1'b1;

    // Full window from slot 0, pulse on the close slot included.
    drive_window(8'b1000_0101, 1'b1, 1'b1, 1'b1, 3, 1'b1);
    check("t2_rpt_valid", int'(bus.rpt_valid_o), 1);
    check("t2_total", int'(bus.total_cnt_o), 3);
    check("t2_alarm", int'(bus.alarm_o), 0);
    idle(1'b1);
    check("t2_rpt_valid_drop", int'(bus.rpt_valid_o), 0);

    // Alarm streak windows.
    for (int i = 0; i < 8; i++) begin
      drive_window(tbl[i].mask, 1'b1, 1'b1, 1'b1, tbl[i].cnt, tbl[i].hot);
      check($sformatf("tbl%0d_alarm", i), int'(bus.alarm_o), int'(tbl[i].alarm));
      check($sformatf("tbl%0d_total", i), int'(bus.total_cnt_o), tbl[i].total);
      check($sformatf("tbl%0d_valid", i), int'(bus.rpt_valid_o), 1);
    end
    idle(1'b1);

    // Two closes with no consumer: second report dropped.
    drive_window(8'hB5, 1'b0, 1'b0, 1'b1, 5, 1'b1);
    check("t4_valid", int'(bus.rpt_valid_o), 1);
    check("t4_overrun_first", int'(bus.overrun_o), 0);
    check("t4_alarm_armed", int'(bus.alarm_o), 0);
    check("t4_total_sat", int'(bus.total_cnt_o), 15);
    drive_window(8'h01, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    check("t4_rpt_cnt_kept", int'(bus.rpt_cnt_o), 5);
    check("t4_rpt_hot_kept", int'(bus.rpt_hot_o), 1);
    check("t4_overrun_set", int'(bus.overrun_o), 1);
    check("t4_alarm_low", int'(bus.alarm_o), 0);
    idle(1'b1);
    check("t4_valid_after_accept", int'(bus.rpt_valid_o), 0);
    check("t4_overrun_sticky", int'(bus.overrun_o), 1);
    bus.rpt_ready_i = 1'b0;
    pulse_clr();
    check("t4_clr_total", int'(bus.total_cnt_o), 0);
    check("t4_clr_overrun", int'(bus.overrun_o), 0);

    // Accept and close in the same cycle.
    drive_window(8'h55, 1'b1, 1'b1, 1'b1, 4, 1'b1);
    for (int s = 0; s < WIN_LEN; s++) begin
      bus.en_i               = 1'b1;
      bus.valid_i            = 1'b1;
      bus.pattern_detected_i = (s == 0 || s == WIN_LEN - 1);
      bus.rpt_ready_i        = (s == WIN_LEN - 1);
      if (s == WIN_LEN - 1) expect_rpt(2, 1'b1);
      tick();
      if (s == 3) begin
        check("t5_hold_valid", int'(bus.rpt_valid_o), 1);
        check("t5_hold_cnt", int'(bus.rpt_cnt_o), 4);
      end
    end
    check("t5_no_bubble", int'(bus.rpt_valid_o), 1);
    check("t5_rpt_cnt_new", int'(bus.rpt_cnt_o), 2);
    check("t5_overrun", int'(bus.overrun_o), 0);
    check("t5_alarm", int'(bus.alarm_o), 1);
    idle(1'b1);
    check("t5_valid_drop", int'(bus.rpt_valid_o), 0);
    bus.rpt_ready_i = 1'b0;
    pulse_clr();
    check("t5_clr_alarm", int'(bus.alarm_o), 0);

    // en_i low for 3 slots with 2 pulses, then saturation, then clear.
    for (int s = 0; s < 3; s++) begin
      bus.en_i = 1'b1; bus.valid_i = 1'b1; bus.pattern_detected_i = (s == 1);
      tick();
    end
    check("t6_total_pre_hold", int'(bus.total_cnt_o), 1);
    for (int k = 0; k < 3; k++) begin
      bus.en_i = 1'b0; bus.valid_i = 1'b1; bus.pattern_detected_i = (k != 1);
      tick();
    end
    check("t6_total_hold", int'(bus.total_cnt_o), 1);
    for (int s = 3; s < WIN_LEN; s++) begin
      bus.en_i = 1'b1; bus.valid_i = 1'b1; bus.pattern_detected_i = (s == 5);
      tick();
    end
    check("t6_rpt_valid", int'(bus.rpt_valid_o), 1);
    check("t6_rpt_cnt", int'(bus.rpt_cnt_o), 2);
    check("t6_total_win", int'(bus.total_cnt_o), 2);
    for (int i = 0; i < 18; i++) begin
      bus.en_i = 1'b1; bus.valid_i = 1'b0; bus.pattern_detected_i = 1'b1;
      tick();
      if (i == 11) check("t6_total_14", int'(bus.total_cnt_o), 14);
    end
    check("t6_total_sat", int'(bus.total_cnt_o), 15);
    pulse_clr();
    bus.pattern_detected_i = 1'b0;
    check("t6_clr_total", int'(bus.total_cnt_o), 0);
    check("t6_clr_valid", int'(bus.rpt_valid_o), 0);
    check("t6_clr_overrun", int'(bus.overrun_o), 0);
    check("t6_clr_alarm", int'(bus.alarm_o), 0);
    drive_window(8'h10, 1'b1, 1'b1, 1'b1, 1, 1'b0);
    check("t6_post_clr_total", int'(bus.total_cnt_o), 1);
    check("t6_post_clr_alarm", int'(bus.alarm_o), 0);
    idle(1'b1);
    check("t6_post_clr_valid", int'(bus.rpt_valid_o), 0);

    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
